// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared encodings for the five-stage RISC-V pipeline.
// Revision    : 1.0
// ============================================================================
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational ALU with zero flag for the execute stage.
// Revision    : 1.0
// ============================================================================
module alu
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [2:0]            i_ctrl,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero
);

  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_lt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  // Signed less-than from the true difference: differing signs decide directly.
  assign w_lt   = (i_a[DATA_WIDTH-1] ^ i_b[DATA_WIDTH-1]) ? i_a[DATA_WIDTH-1]
                                                          : w_diff[DATA_WIDTH-1];

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD: o_result = w_sum;
      ALU_SUB: o_result = w_diff;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLT: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : RISC-V EX stage: forwarding, ALU, branch target, EX/MEM reg.
// Revision    : 1.0
// ============================================================================
module execute_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_regwrite_e,
  input  logic [1:0]            i_resultsrc_e,
  input  logic                  i_memwrite_e,
  input  logic [2:0]            i_aluctrl_e,
  input  logic                  i_alusrc_e,
  input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
  input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
  input  logic [DATA_WIDTH-1:0] i_pc_e,
  input  logic [DATA_WIDTH-1:0] i_pc4_e,
  input  logic [DATA_WIDTH-1:0] i_immext_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic [1:0]            i_forward_a_e,
  input  logic [1:0]            i_forward_b_e,
  input  logic [DATA_WIDTH-1:0] i_result_w,
  output logic                  o_zero_e,
  output logic [DATA_WIDTH-1:0] o_pc_target_e,
  output logic                  o_regwrite_m,
  output logic                  o_memwrite_m,
  output logic [1:0]            o_resultsrc_m,
  output logic [DATA_WIDTH-1:0] o_alu_result_m,
  output logic [DATA_WIDTH-1:0] o_write_data_m,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_m,
  output logic [DATA_WIDTH-1:0] o_pc4_m
);

  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic [DATA_WIDTH-1:0] w_write_data;
  logic [DATA_WIDTH-1:0] w_alu_result;

  logic                  r_regwrite_m;
  logic                  r_memwrite_m;
  logic [1:0]            r_resultsrc_m;
  logic [DATA_WIDTH-1:0] r_alu_result_m;
  logic [DATA_WIDTH-1:0] r_write_data_m;
  logic [ADDR_WIDTH-1:0] r_rd_addr_m;
  logic [DATA_WIDTH-1:0] r_pc4_m;

  // Select 11 is unused by the hazard unit and falls back to register data.
  always_comb begin
    w_src_a = i_rs1_data_e;
    case (i_forward_a_e)
      FWD_WB:  w_src_a = i_result_w;
      FWD_MEM: w_src_a = r_alu_result_m;
      default: w_src_a = i_rs1_data_e;
    endcase
  end

  always_comb begin
    w_write_data = i_rs2_data_e;
    case (i_forward_b_e)
      FWD_WB:  w_write_data = i_result_w;
      FWD_MEM: w_write_data = r_alu_result_m;
      default: w_write_data = i_rs2_data_e;
    endcase
  end

  assign w_src_b       = i_alusrc_e ? i_immext_e : w_write_data;
  assign o_pc_target_e = i_pc_e + i_immext_e;

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_a      (w_src_a),
    .i_b      (w_src_b),
    .i_ctrl   (i_aluctrl_e),
    .o_result (w_alu_result),
    .o_zero   (o_zero_e)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regwrite_m   <= 1'b0;
      r_memwrite_m   <= 1'b0;
      r_resultsrc_m  <= 2'b00;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_rd_addr_m    <= '0;
      r_pc4_m        <= '0;
    end else begin
      r_regwrite_m   <= i_regwrite_e;
      r_memwrite_m   <= i_memwrite_e;
      r_resultsrc_m  <= i_resultsrc_e;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_write_data;
      r_rd_addr_m    <= i_rd_addr_e;
      r_pc4_m        <= i_pc4_e;
    end
  end

  assign o_regwrite_m   = r_regwrite_m;
  assign o_memwrite_m   = r_memwrite_m;
  assign o_resultsrc_m  = r_resultsrc_m;
  assign o_alu_result_m = r_alu_result_m;
  assign o_write_data_m = r_write_data_m;
  assign o_rd_addr_m    = r_rd_addr_m;
  assign o_pc4_m        = r_pc4_m;

endmodule
`default_nettype wire
